ram_responder: RTL and testbench

- Behavioural, synthesizable RAM responder: the other end of the RAM interface that memory_control drives (ramREN/ramWEN/ramaddr/ramstore in, ramload/ramstate out).
- Word-addressed storage with a programmable access latency; reports FREE/BUSY/ACCESS/ERROR.
- Sits below memory_control in the system top and in the memory-subsystem benches; replaces the vendor RAM model for latency-sweep testing.

---
 rtl/cpu_types_pkg.sv | 13 +
 rtl/ram_responder_pkg.sv | 12 +
 rtl/ram_responder_if.sv | 21 ++
 rtl/ram_responder_word_array.sv | 21 ++
 rtl/ram_responder.sv | 101 ++++++++++
 tb/tb_ram_responder.sv | 314 +++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: machine word and RAM handshake state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/ram_responder_pkg.sv
// Local types for the RAM responder FSM and latency counter.
package ram_responder_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } resp_state_t;

endpackage

// File: rtl/ram_responder_if.sv
// RAM request/response bus between memory_control (master) and the RAM (slave).
interface ram_responder_if;
    import cpu_types_pkg::*;

    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport master (
        output ramREN, ramWEN, ramaddr, ramstore,
        input  ramload, ramstate
    );

    modport slave (
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramstate
    );
endinterface

// File: rtl/ram_responder_word_array.sv
// Word storage: synchronous write, asynchronous read, contents not reset.
module ram_word_array
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     CLK,
    input  logic                     wen,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  word_t                    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output word_t                    rdata
);
    word_t r_mem [DEPTH];

    always_ff @(posedge CLK) begin
        if (wen) r_mem[waddr] <= wdata;
    end

    assign rdata = r_mem[raddr];
endmodule

// File: rtl/ram_responder.sv
// RAM responder with programmable access latency; answers memory_control's
// REN/WEN requests with FREE/BUSY/ACCESS/ERROR.
module ram_responder
    import ram_responder_pkg::*;
#(
    parameter int unsigned LAT   = 2,
    parameter int unsigned DEPTH = 1024
) (
    input  logic           CLK,
    input  logic           RST,
    ram_responder_if.slave ram
);
    localparam int unsigned        AW       = $clog2(DEPTH);
    localparam cpu_types_pkg::word_t ADDR_LIM = cpu_types_pkg::word_t'(DEPTH * 4);
    localparam logic [CNT_W-1:0]   CNT_INIT = (LAT >= 2) ? CNT_W'(LAT - 2) : '0;

    resp_state_t          r_state, w_next;
    logic [CNT_W-1:0]     r_cnt, w_cnt_next;
    cpu_types_pkg::word_t r_addr;
    logic                 r_wr;
    logic                 w_req, w_err, w_changed, w_latch, w_wen;
    cpu_types_pkg::word_t w_rdata;

    assign w_req = ram.ramREN | ram.ramWEN;
    assign w_err = (ram.ramREN & ram.ramWEN) | (ram.ramaddr[1:0] != 2'b00) |
                   (ram.ramaddr >= ADDR_LIM);
    // Any difference from the latched request aborts an in-flight access.
    assign w_changed = ~w_req | (ram.ramaddr != r_addr) | (ram.ramWEN != r_wr);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_latch) begin
                r_addr <= ram.ramaddr;
                r_wr   <= ram.ramWEN;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        w_cnt_next   = r_cnt;
        w_latch      = 1'b0;
        w_wen        = 1'b0;
        ram.ramstate = cpu_types_pkg::FREE;
        ram.ramload  = '0;
        if (w_err) begin
            ram.ramstate = cpu_types_pkg::ERROR;
            w_next       = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        ram.ramstate = cpu_types_pkg::BUSY;
                        w_latch      = 1'b1;
                        w_cnt_next   = CNT_INIT;
                        w_next       = (LAT == 1) ? ACCESS : WAIT;
                    end
                end
                WAIT: begin
                    if (w_changed) begin
                        ram.ramstate = w_req ? cpu_types_pkg::BUSY : cpu_types_pkg::FREE;
                        w_next       = IDLE;
                    end else begin
                        ram.ramstate = cpu_types_pkg::BUSY;
                        if (r_cnt != '0) w_cnt_next = r_cnt - CNT_W'(1);
                        else             w_next     = ACCESS;
                    end
                end
                ACCESS: begin
                    w_next = IDLE;
                    if (w_changed) begin
                        ram.ramstate = w_req ? cpu_types_pkg::BUSY : cpu_types_pkg::FREE;
                    end else begin
                        ram.ramstate = cpu_types_pkg::ACCESS;
                        if (r_wr) w_wen       = ~RST;
                        else      ram.ramload = w_rdata;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    ram_word_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .CLK   (CLK),
        .wen   (w_wen),
        .waddr (r_addr[AW+1:2]),
        .wdata (ram.ramstore),
        .raddr (r_addr[AW+1:2]),
        .rdata (w_rdata)
    );
endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: four instances with LAT=1..4 share one
// stimulus stream; each scenario checks the instance whose latency it targets.
module tb_ram_responder;
    import cpu_types_pkg::*;

    typedef struct packed {
        logic      rst;
        logic      r;
        logic      w;
        word_t     a;
        word_t     d;
        logic      chk;
        ramstate_t es;
        word_t     el;
    } row_t;

    typedef struct packed {
        ramstate_t st;
        word_t     ld;
    } exp_t;

    logic      clk;
    logic      rst, ren, wen;
    word_t     addr, store;
    logic [1:0] sel;
    ramstate_t obs_state;
    word_t     obs_load;
    ramstate_t st_a [4];
    word_t     ld_a [4];
    exp_t      sb [$];
    int        vectors, miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ram_responder_if bus ();
        assign bus.ramREN   = ren;
        assign bus.ramWEN   = wen;
        assign bus.ramaddr  = addr;
        assign bus.ramstore = store;
        assign st_a[g]      = bus.ramstate;
        assign ld_a[g]      = bus.ramload;
        ram_responder #(.LAT(g + 1), .DEPTH(1024)) u_dut (
            .CLK (clk),
            .RST (rst),
            .ram (bus)
        );
    end

    always_comb begin
        obs_state = st_a[sel];
        obs_load  = ld_a[sel];
    end

    function automatic row_t ck(input logic rd, input logic wr, input word_t ad,
                                input word_t dt, input ramstate_t xs, input word_t xl);
        row_t x;
        x = '{rst: 1'b0, r: rd, w: wr, a: ad, d: dt, chk: 1'b1, es: xs, el: xl};
        return x;
    endfunction

    function automatic row_t idl();
        return ck(1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
    endfunction

    // Inputs change on the falling edge and outputs are sampled 1 time unit later.
    task automatic drive(input row_t x);
        @(negedge clk);
        rst   = x.rst;
        ren   = x.r;
        wen   = x.w;
        addr  = x.a;
        store = x.d;
        #1;
    endtask

    task automatic test_reset();
        row_t rows[$];
        exp_t e;
        row_t x;
        sel = 2'd0;
        x = idl(); x.rst = 1'b1;
        rows.push_back(x);
        rows.push_back(x);
        rows.push_back(idl());
        foreach (rows[i]) begin
            if (rows[i].chk) sb.push_back(exp_t'{rows[i].es, rows[i].el});
            drive(rows[i]);
            if (rows[i].chk) begin
                e = sb.pop_front();
                vectors++;
                if (obs_state !== e.st || obs_load !== e.ld) begin
                    miscompares++;
                    $display("FAIL reset[%0d]: got state=%0d load=%h, want state=%0d load=%h",
                             i, obs_state, obs_load, e.st, e.ld);
                end
            end
        end
    endtask

    task automatic test_write_read();
        row_t rows[$];
        exp_t e;
        sel = 2'd1;
        rows.push_back(ck(0, 1, 32'h40, 32'hDEADBEEF, BUSY,   32'h0));
        rows.push_back(ck(0, 1, 32'h40, 32'hDEADBEEF, BUSY,   32'h0));
        rows.push_back(ck(0, 1, 32'h40, 32'hDEADBEEF, ACCESS, 32'h0));
        rows.push_back(idl());
        rows.push_back(ck(1, 0, 32'h40, 32'h0, BUSY,   32'h0));
        rows.push_back(ck(1, 0, 32'h40, 32'h0, BUSY,   32'h0));
        rows.push_back(ck(1, 0, 32'h40, 32'h0, ACCESS, 32'hDEADBEEF));
        rows.push_back(idl());
        foreach (rows[i]) begin
            if (rows[i].chk) sb.push_back(exp_t'{rows[i].es, rows[i].el});
            drive(rows[i]);
            if (rows[i].chk) begin
                e = sb.pop_front();
                vectors++;
                if (obs_state !== e.st || obs_load !== e.ld) begin
                    miscompares++;
                    $display("FAIL write_read[%0d]: got state=%0d load=%h, want state=%0d load=%h",
                             i, obs_state, obs_load, e.st, e.ld);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        exp_t e;
        sel = 2'd0;
        rows.push_back(ck(0, 1, 32'h0, 32'h11, BUSY,   32'h0));
        rows.push_back(ck(0, 1, 32'h0, 32'h11, ACCESS, 32'h0));
        rows.push_back(ck(0, 1, 32'h4, 32'h22, BUSY,   32'h0));
        rows.push_back(ck(0, 1, 32'h4, 32'h22, ACCESS, 32'h0));
        rows.push_back(idl());
        rows.push_back(ck(1, 0, 32'h0, 32'h0, BUSY,   32'h0));
        rows.push_back(ck(1, 0, 32'h0, 32'h0, ACCESS, 32'h11));
        rows.push_back(ck(1, 0, 32'h4, 32'h0, BUSY,   32'h0));
        rows.push_back(ck(1, 0, 32'h4, 32'h0, ACCESS, 32'h22));
        rows.push_back(idl());
        foreach (rows[i]) begin
            if (rows[i].chk) sb.push_back(exp_t'{rows[i].es, rows[i].el});
            drive(rows[i]);
            if (rows[i].chk) begin
                e = sb.pop_front();
                vectors++;
                if (obs_state !== e.st || obs_load !== e.ld) begin
                    miscompares++;
                    $display("FAIL back_to_back[%0d]: got state=%0d load=%h, want state=%0d load=%h",
                             i, obs_state, obs_load, e.st, e.ld);
                end
            end
        end
    endtask

    task automatic test_abort();
        row_t rows[$];
        exp_t e;
        sel = 2'd3;
        for (int c = 0; c < 4; c++) rows.push_back(ck(0, 1, 32'h84, 32'h5A5A0084, BUSY, 32'h0));
        rows.push_back(ck(0, 1, 32'h84, 32'h5A5A0084, ACCESS, 32'h0));
        rows.push_back(idl());
        // Address change mid-wait: 0x80 never reaches ACCESS, 0x84 restarts in cycle 3.
        rows.push_back(ck(1, 0, 32'h80, 32'h0, BUSY, 32'h0));
        rows.push_back(ck(1, 0, 32'h80, 32'h0, BUSY, 32'h0));
        for (int c = 2; c < 7; c++) rows.push_back(ck(1, 0, 32'h84, 32'h0, BUSY, 32'h0));
        rows.push_back(ck(1, 0, 32'h84, 32'h0, ACCESS, 32'h5A5A0084));
        rows.push_back(idl());
        // Write dropped in its ACCESS cycle must not commit.
        for (int c = 0; c < 4; c++) rows.push_back(ck(0, 1, 32'h84, 32'hFFFFFFFF, BUSY, 32'h0));
        rows.push_back(idl());
        for (int c = 0; c < 4; c++) rows.push_back(ck(1, 0, 32'h84, 32'h0, BUSY, 32'h0));
        rows.push_back(ck(1, 0, 32'h84, 32'h0, ACCESS, 32'h5A5A0084));
        rows.push_back(idl());
        foreach (rows[i]) begin
            if (rows[i].chk) sb.push_back(exp_t'{rows[i].es, rows[i].el});
            drive(rows[i]);
            if (rows[i].chk) begin
                e = sb.pop_front();
                vectors++;
                if (obs_state !== e.st || obs_load !== e.ld) begin
                    miscompares++;
                    $display("FAIL abort[%0d]: got state=%0d load=%h, want state=%0d load=%h",
                             i, obs_state, obs_load, e.st, e.ld);
                end
            end
        end
    endtask

    task automatic test_error();
        row_t rows[$];
        exp_t e;
        sel = 2'd1;
        rows.push_back(ck(0, 1, 32'h10, 32'h10101010, BUSY,   32'h0));
        rows.push_back(ck(0, 1, 32'h10, 32'h10101010, BUSY,   32'h0));
        rows.push_back(ck(0, 1, 32'h10, 32'h10101010, ACCESS, 32'h0));
        rows.push_back(idl());
        rows.push_back(ck(1, 1, 32'h10,   32'hBAD0BAD0, ERROR, 32'h0));
        rows.push_back(idl());
        rows.push_back(ck(1, 0, 32'h12,   32'h0,        ERROR, 32'h0));
        rows.push_back(ck(1, 0, 32'h1000, 32'h0,        ERROR, 32'h0));
        rows.push_back(idl());
        rows.push_back(ck(0, 1, 32'h10,   32'hBAD0BAD0, BUSY,  32'h0));
        rows.push_back(ck(1, 1, 32'h10,   32'hBAD0BAD0, ERROR, 32'h0));
        rows.push_back(idl());
        rows.push_back(ck(1, 0, 32'h10, 32'h0, BUSY,   32'h0));
        rows.push_back(ck(1, 0, 32'h10, 32'h0, BUSY,   32'h0));
        rows.push_back(ck(1, 0, 32'h10, 32'h0, ACCESS, 32'h10101010));
        rows.push_back(idl());
        // Last legal word address.
        rows.push_back(ck(0, 1, 32'hFFC, 32'h0FFC0FFC, BUSY,   32'h0));
        rows.push_back(ck(0, 1, 32'hFFC, 32'h0FFC0FFC, BUSY,   32'h0));
        rows.push_back(ck(0, 1, 32'hFFC, 32'h0FFC0FFC, ACCESS, 32'h0));
        rows.push_back(idl());
        rows.push_back(ck(1, 0, 32'hFFC, 32'h0, BUSY,   32'h0));
        rows.push_back(ck(1, 0, 32'hFFC, 32'h0, BUSY,   32'h0));
        rows.push_back(ck(1, 0, 32'hFFC, 32'h0, ACCESS, 32'h0FFC0FFC));
        rows.push_back(idl());
        foreach (rows[i]) begin
            if (rows[i].chk) sb.push_back(exp_t'{rows[i].es, rows[i].el});
            drive(rows[i]);
            if (rows[i].chk) begin
                e = sb.pop_front();
                vectors++;
                if (obs_state !== e.st || obs_load !== e.ld) begin
                    miscompares++;
                    $display("FAIL error[%0d]: got state=%0d load=%h, want state=%0d load=%h",
                             i, obs_state, obs_load, e.st, e.ld);
                end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        row_t rows[$];
        exp_t e;
        row_t x;
        sel = 2'd2;
        for (int c = 0; c < 3; c++) rows.push_back(ck(0, 1, 32'h20, 32'h0, BUSY, 32'h0));
        rows.push_back(ck(0, 1, 32'h20, 32'h0, ACCESS, 32'h0));
        rows.push_back(idl());
        for (int c = 0; c < 3; c++) rows.push_back(ck(0, 1, 32'h20, 32'hCAFE0001, BUSY, 32'h0));
        x = ck(0, 1, 32'h20, 32'hCAFE0001, ACCESS, 32'h0);
        x.rst = 1'b1;
        x.chk = 1'b0;
        rows.push_back(x);
        rows.push_back(idl());
        for (int c = 0; c < 3; c++) rows.push_back(ck(1, 0, 32'h20, 32'h0, BUSY, 32'h0));
        rows.push_back(ck(1, 0, 32'h20, 32'h0, ACCESS, 32'h0));
        rows.push_back(idl());
        foreach (rows[i]) begin
            if (rows[i].chk) sb.push_back(exp_t'{rows[i].es, rows[i].el});
            drive(rows[i]);
            if (rows[i].chk) begin
                e = sb.pop_front();
                vectors++;
                if (obs_state !== e.st || obs_load !== e.ld) begin
                    miscompares++;
                    $display("FAIL reset_mid_access[%0d]: got state=%0d load=%h, want state=%0d load=%h",
                             i, obs_state, obs_load, e.st, e.ld);
                end
            end
        end
    endtask

    task automatic test_store_change();
        row_t rows[$];
        exp_t e;
        sel = 2'd1;
        rows.push_back(ck(0, 1, 32'h30, 32'h1, BUSY,   32'h0));
        rows.push_back(ck(0, 1, 32'h30, 32'h1, BUSY,   32'h0));
        rows.push_back(ck(0, 1, 32'h30, 32'h2, ACCESS, 32'h0));
        rows.push_back(idl());
        rows.push_back(ck(1, 0, 32'h30, 32'h0, BUSY,   32'h0));
        rows.push_back(ck(1, 0, 32'h30, 32'h0, BUSY,   32'h0));
        rows.push_back(ck(1, 0, 32'h30, 32'h0, ACCESS, 32'h2));
        rows.push_back(idl());
        foreach (rows[i]) begin
            if (rows[i].chk) sb.push_back(exp_t'{rows[i].es, rows[i].el});
            drive(rows[i]);
            if (rows[i].chk) begin
                e = sb.pop_front();
                vectors++;
                if (obs_state !== e.st || obs_load !== e.ld) begin
                    miscompares++;
                    $display("FAIL store_change[%0d]: got state=%0d load=%h, want state=%0d load=%h",
                             i, obs_state, obs_load, e.st, e.ld);
                end
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        ren         = 1'b0;
        wen         = 1'b0;
        addr        = '0;
        store       = '0;
        sel         = 2'd0;
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_abort();
        test_error();
        test_reset_mid_access();
        test_store_change();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
